// File: rtl/thermo_conf_arbiter.sv
// -----------------------------------------------------------------------------
// thermo_conf_arbiter
//
// Purpose:
//   Shares one configuration FSM (4-bit code entry through start/in, result on
//   hit/out) between NUM_ROOMS room panels. Requests are arbitrated
//   round-robin. The granted room's button line is forwarded to the FSM. The
//   4-bit result is captured into that room's setpoint register. A session
//   ends in one of three ways: a captured result (done), the requester
//   dropping req (abort), or a cycle limit (timeout). Each session is followed
//   by an idle gap with conf_start low, so the FSM always restarts clean.
//
// Handshake:
//   req is a level signal held for the whole session. grant and conf_start
//   rise one cycle after the arbiter sees req in IDLE. A result is accepted
//   only in a RUN cycle with conf_hit=1. conf_hit and conf_out are ignored in
//   every other cycle.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active-low
//   req         in   per-room request levels
//   btn         in   per-room button lines
//   conf_hit    in   config FSM result valid
//   conf_out    in   config FSM result code
//   conf_start  out  FSM start (registered)
//   conf_in     out  FSM in, which is btn of the granted room while in RUN
//                    (combinational)
//   grant       out  one-hot grant, zero when no session
//   busy        out  high in RUN and RELEASE
//   done        out  one-cycle pulse: setpoint captured
//   abort       out  one-cycle pulse: requester dropped req
//   timeout     out  one-cycle pulse: session cycle limit reached
//   done_room   out  room of the session that just ended
//   setpoints   out  room k setpoint in bits [4k+3:4k]
//   dbg_state   out  current FSM state (0 IDLE, 1 RUN, 2 RELEASE)
// -----------------------------------------------------------------------------
module thermo_conf_arbiter #(
    parameter int         NUM_ROOMS   = 4,
    parameter int         TIMEOUT_CYC = 64,
    parameter int         GAP_CYC     = 2,
    parameter logic [3:0] DEFAULT_SP  = 4'd8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_ROOMS-1:0]           req,
    input  logic [NUM_ROOMS-1:0]           btn,
    input  logic                           conf_hit,
    input  logic [3:0]                     conf_out,
    output logic                           conf_start,
    output logic                           conf_in,
    output logic [NUM_ROOMS-1:0]           grant,
    output logic                           busy,
    output logic                           done,
    output logic                           abort,
    output logic                           timeout,
    output logic [$clog2(NUM_ROOMS)-1:0]   done_room,
    output logic [4*NUM_ROOMS-1:0]         setpoints,
    output logic [1:0]                     dbg_state
);

    localparam int IW = $clog2(NUM_ROOMS);
    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                 r_state,      w_state_nxt;
    logic [IW-1:0]          r_ptr,        w_ptr_nxt;
    logic [IW-1:0]          r_idx,        w_idx_nxt;
    logic [CW-1:0]          r_cnt,        w_cnt_nxt;
    logic [GW-1:0]          r_gap,        w_gap_nxt;
    logic [NUM_ROOMS-1:0]   r_grant,      w_grant_nxt;
    logic                   r_conf_start, w_start_nxt;
    logic                   r_busy,       w_busy_nxt;
    logic                   r_done,       w_done_nxt;
    logic                   r_abort,      w_abort_nxt;
    logic                   r_timeout,    w_timeout_nxt;
    logic [IW-1:0]          r_done_room,  w_done_room_nxt;
    logic [4*NUM_ROOMS-1:0] r_setpoints,  w_sp_nxt;

    logic                   w_found;
    logic [IW-1:0]          w_winner;
    logic [IW-1:0]          w_cand;
    logic                   w_end;

    // Round-robin search: start at the room after the last one served
    // and wrap, so the room served last has the lowest priority.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 1; k <= NUM_ROOMS; k++) begin
            w_cand = IW'((int'(r_ptr) + k) % NUM_ROOMS);
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_gap_nxt       = r_gap;
        w_grant_nxt     = r_grant;
        w_start_nxt     = r_conf_start;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_abort_nxt     = 1'b0;
        w_timeout_nxt   = 1'b0;
        w_done_room_nxt = r_done_room;
        w_sp_nxt        = r_setpoints;
        w_end           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_RUN;
                    w_idx_nxt   = w_winner;
                    w_grant_nxt = NUM_ROOMS'(1) << w_winner;
                    w_start_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end

            ST_RUN: begin
                // A result outranks a dropped request and a timeout in the same cycle.
                if (conf_hit) begin
                    w_sp_nxt[{r_idx, 2'b00} +: 4] = conf_out;
                    w_done_nxt = 1'b1;
                    w_end      = 1'b1;
                end else if (!req[r_idx]) begin
                    w_abort_nxt = 1'b1;
                    w_end       = 1'b1;
                end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
                    w_timeout_nxt = 1'b1;
                    w_end         = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end

                if (w_end) begin
                    w_state_nxt     = ST_RELEASE;
                    w_grant_nxt     = '0;
                    w_start_nxt     = 1'b0;
                    w_done_room_nxt = r_idx;
                    w_ptr_nxt       = r_idx;
                    w_gap_nxt       = '0;
                end
            end

            ST_RELEASE: begin
                if (r_gap == GW'(GAP_CYC - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_start_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= IW'(NUM_ROOMS - 1);
            r_idx        <= '0;
            r_cnt        <= '0;
            r_gap        <= '0;
            r_grant      <= '0;
            r_conf_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_abort      <= 1'b0;
            r_timeout    <= 1'b0;
            r_done_room  <= '0;
            r_setpoints  <= {NUM_ROOMS{DEFAULT_SP}};
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_gap        <= w_gap_nxt;
            r_grant      <= w_grant_nxt;
            r_conf_start <= w_start_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_abort      <= w_abort_nxt;
            r_timeout    <= w_timeout_nxt;
            r_done_room  <= w_done_room_nxt;
            r_setpoints  <= w_sp_nxt;
        end
    end

    // Only the button pass-through is combinational. The FSM sees
    // the panel's button with no added delay.
    assign conf_in    = (r_state == ST_RUN) ? btn[r_idx] : 1'b0;
    assign conf_start = r_conf_start;
    assign grant      = r_grant;
    assign busy       = r_busy;
    assign done       = r_done;
    assign abort      = r_abort;
    assign timeout    = r_timeout;
    assign done_room  = r_done_room;
    assign setpoints  = r_setpoints;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_thermo_conf_arbiter.sv
module tb_thermo_conf_arbiter;

  localparam int N   = 4;
  localparam int TO  = 64;
  localparam int GAP = 2;
  localparam logic [3:0] DEF = 4'd8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req = '0;
  logic [N-1:0]   btn = '0;
  logic           conf_hit = 1'b0;
  logic [3:0]     conf_out = '0;
  logic           conf_start, conf_in, busy, done, abort, timeout;
  logic [N-1:0]   grant;
  logic [1:0]     done_room;
  logic [4*N-1:0] setpoints;
  logic [1:0]     dbg_state;

  thermo_conf_arbiter #(
    .NUM_ROOMS(N), .TIMEOUT_CYC(TO), .GAP_CYC(GAP), .DEFAULT_SP(DEF)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .btn(btn),
    .conf_hit(conf_hit), .conf_out(conf_out),
    .conf_start(conf_start), .conf_in(conf_in), .grant(grant),
    .busy(busy), .done(done), .abort(abort), .timeout(timeout),
    .done_room(done_room), .setpoints(setpoints), .dbg_state(dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Sessions are modelled as "who holds the FSM, for how long", and
  // gaps as "cycles left before the next grant is possible".
  bit         m_active;
  int         m_room, m_elapsed, m_gap_left, m_ptr, m_last;
  logic [3:0] m_sp [N];
  bit         m_done, m_abort, m_timeout;

  function automatic void model_reset();
    m_active = 0; m_room = 0; m_elapsed = 0; m_gap_left = 0;
    m_ptr = N - 1; m_last = 0;
    m_done = 0; m_abort = 0; m_timeout = 0;
    for (int i = 0; i < N; i++) m_sp[i] = DEF;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic h, input logic [3:0] o);
    m_done = 0; m_abort = 0; m_timeout = 0;
    if (m_active) begin
      if (h) begin
        m_sp[m_room] = o;
        m_done = 1;
      end else if (!r[m_room]) m_abort = 1;
      else if (m_elapsed == TO - 1) m_timeout = 1;
      else m_elapsed++;
      if (m_done || m_abort || m_timeout) begin
        m_active = 0; m_gap_left = GAP; m_last = m_room; m_ptr = m_room;
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else if (r != '0) begin
      for (int k = 1; k <= N; k++) begin
        if (r[(m_ptr + k) % N]) begin
          m_room = (m_ptr + k) % N;
          break;
        end
      end
      m_active = 1; m_elapsed = 0;
    end
  endfunction

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_active) g[m_room] = 1'b1;
    return g;
  endfunction

  function automatic logic [4*N-1:0] exp_sp();
    logic [4*N-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s[4*i +: 4] = m_sp[i];
    return s;
  endfunction

  // ---------------- compare process ----------------
  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("grant",      grant,      exp_grant());
      check("conf_start", conf_start, m_active);
      check("busy",       busy,       m_active || (m_gap_left > 0));
      check("done",       done,       m_done);
      check("abort",      abort,      m_abort);
      check("timeout",    timeout,    m_timeout);
      check("done_room",  done_room,  m_last);
      check("setpoints",  setpoints,  exp_sp());
      check("conf_in",    conf_in,    m_active ? btn[m_room] : 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at negedge+2: apply inputs, advance the model over the coming
  // rising edge, then wait to the next negedge+2.
  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] b, input logic h, input logic [3:0] o);
    req = r; btn = b; conf_hit = h; conf_out = o;
    if (rst) model_step(r, h, o);
    @(negedge clk); #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0; btn = '0; conf_hit = 1'b0; conf_out = '0;
    model_reset();
    @(negedge clk); #2;
    rst = 1'b1;
  endtask

  task automatic rand_phase(input int hit_pct, input int flip_pct, input int len);
    logic [N-1:0] r;
    r = N'($urandom_range(1, (1 << N) - 1));
    for (int c = 0; c < len; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 99) < flip_pct) r[i] = ~r[i];
      cyc(r, N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 99) < hit_pct),
          4'($urandom_range(0, 15)));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int k;
    bit seen;
    logic [N-1:0] exp_g;

    model_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_grant",      grant,      4'b0000);
    check("rst_conf_start", conf_start, 1'b0);
    check("rst_busy",       busy,       1'b0);
    check("rst_pulses",     {done, abort, timeout}, 3'b000);
    check("rst_done_room",  done_room,  2'd0);
    check("rst_setpoints",  setpoints,  16'h8888);
    chk_en = 1;
    rst = 1'b1;

    // Single request from room 2.
    cyc(4'b0100, 4'b0000, 1'b0, 4'd0);
    check("single_grant", grant, 4'b0100);
    check("single_start", conf_start, 1'b1);
    cyc(4'b0100, 4'b0100, 1'b0, 4'd0);
    check("single_conf_in_hi", conf_in, 1'b1);
    cyc(4'b0100, 4'b0000, 1'b0, 4'd0);
    check("single_conf_in_lo", conf_in, 1'b0);
    cyc(4'b0100, 4'b0000, 1'b1, 4'd5);
    check("single_done", done, 1'b1);
    check("single_done_room", done_room, 2'd2);
    check("single_sp2", setpoints[11:8], 4'd5);
    check("single_start_lo", conf_start, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0, 4'd0);
    check("single_gap_busy", busy, 1'b1);
    check("single_gap_start", conf_start, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0, 4'd0);
    check("single_idle_busy", busy, 1'b0);

    // Round-robin with all rooms requesting.
    do_reset();
    for (int s = 0; s < 5; s++) begin
      for (int w = 0; w < 8 && grant == '0; w++) cyc(4'hF, 4'h0, 1'b0, 4'd0);
      exp_g = N'(1) << (s % N);
      check("rr_grant_order", grant, exp_g);
      cyc(4'hF, 4'h0, 1'b1, 4'(s + 1));
      if (s == 3) check("rr_setpoints", setpoints, 16'h4321);
    end
    repeat (3) cyc(4'h0, 4'h0, 1'b0, 4'd0);

    // Abort from room 1.
    do_reset();
    cyc(4'b0010, 4'b0000, 1'b0, 4'd0);
    check("abort_grant", grant, 4'b0010);
    repeat (10) cyc(4'b0010, N'($urandom_range(0, 15)), 1'b0, 4'd0);
    cyc(4'b0000, 4'b0000, 1'b0, 4'd0);
    check("abort_pulse", abort, 1'b1);
    check("abort_no_done", done, 1'b0);
    check("abort_done_room", done_room, 2'd1);
    check("abort_sp1", setpoints[7:4], 4'd8);
    repeat (3) cyc(4'b0000, 4'b0000, 1'b0, 4'd0);

    // Timeout on room 3, then room 0 next.
    do_reset();
    cyc(4'b1000, 4'b0000, 1'b0, 4'd0);
    check("to_grant", grant, 4'b1000);
    k = 0; seen = 0;
    while (!seen && k < 100) begin
      cyc(4'b1001, N'($urandom_range(0, 15)), 1'b0, 4'd0);
      k++;
      if (timeout) seen = 1;
    end
    check("to_latency", k, 64);
    check("to_sp3", setpoints[15:12], 4'd8);
    check("to_done_room", done_room, 2'd3);
    cyc(4'b1001, 4'b0000, 1'b0, 4'd0);
    check("to_gap_start1", conf_start, 1'b0);
    cyc(4'b1001, 4'b0000, 1'b0, 4'd0);
    check("to_gap_start2", conf_start, 1'b0);
    cyc(4'b1001, 4'b0000, 1'b0, 4'd0);
    check("to_next_grant", grant, 4'b0001);

    // Hit together with req drop: done wins. Later hits are ignored.
    cyc(4'b1000, 4'b0000, 1'b1, 4'd9);
    check("prio_done", done, 1'b1);
    check("prio_no_abort", abort, 1'b0);
    check("prio_sp0", setpoints[3:0], 4'd9);
    repeat (4) cyc(4'b0000, 4'b0000, 1'b1, 4'hF);
    check("prio_ignored_hit", setpoints, 16'h8889);

    // Asynchronous reset in the middle of a session.
    cyc(4'b0100, 4'b0000, 1'b0, 4'd0);
    cyc(4'b0100, 4'b0100, 1'b0, 4'd0);
    check("arst_pre_grant", grant, 4'b0100);
    #1 rst = 1'b0;
    #1;
    check("arst_grant", grant, 4'b0000);
    check("arst_start", conf_start, 1'b0);
    check("arst_sp", setpoints, 16'h8888);
    model_reset();
    req = '0; btn = '0; conf_hit = 1'b0;
    @(negedge clk); #2;
    rst = 1'b1;

    // Randomized traffic.
    rand_phase(10, 5, 600);
    rand_phase(0, 0, 400);
    rand_phase(20, 2, 600);
    rand_phase(3, 1, 600);
    repeat (4) cyc(4'h0, 4'h0, 1'b0, 4'd0);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/thermo_conf_arbiter.md
Name: thermo_conf_arbiter

Overview:
- Shares the single configuration FSM (4-bit code entry via start/in, result on hit/out) between NUM_ROOMS room panels.
- Arbitrates room requests round-robin and drives the FSM's start and in lines for the granted room.
- Captures the 4-bit result into a per-room setpoint register bank.
- Enforces a timeout and a mandatory idle gap between sessions so the FSM always restarts clean.

Parameters:
NUM_ROOMS, 4, number of requesting room panels (2..8)
TIMEOUT_CYC, 64, maximum RUN cycles per session before forced release (>=2)
GAP_CYC, 2, cycles conf_start is held low between sessions (>=1)
DEFAULT_SP, 4'd8, reset value of every setpoint register

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
req  in  NUM_ROOMS  per-room configuration request, level, held for whole session
btn  in  NUM_ROOMS  per-room button line, forwarded to FSM when granted
conf_hit  in  1  config FSM result valid
conf_out  in  4  config FSM result code
conf_start  out  1  drives FSM start
conf_in  out  1  drives FSM in
grant  out  NUM_ROOMS  one-hot grant, all-zero when no session
busy  out  1  high in RUN and RELEASE
done  out  1  one-cycle pulse: setpoint captured
abort  out  1  one-cycle pulse: requester dropped req mid-session
timeout  out  1  one-cycle pulse: TIMEOUT_CYC expired
done_room  out  $clog2(NUM_ROOMS)  index of room just finished; valid with any of the three pulses
setpoints  out  4*NUM_ROOMS  room k setpoint in bits [4k+3:4k]

Behaviour:
- Reset (rst=0, async): state IDLE; ptr=NUM_ROOMS-1; grant=0; conf_start=0; busy=0; pulses=0; done_room=0; cnt=0; every setpoint=DEFAULT_SP.
- All outputs except conf_in are registered. conf_in = btn[idx] while in RUN, else 0. This is a combinational pass-through.
- State IDLE:
  - If |req, the winner is the first set bit searching ptr+1, ptr+2, ... with wrap-around.
  - Next cycle: state RUN, idx=winner, grant[idx]=1, conf_start=1, busy=1, cnt=0.
  - Latency from req to grant/conf_start is 1 cycle.
- State RUN, evaluated each cycle in priority order:
  1. conf_hit=1: setpoints[idx] <= conf_out; done pulse.
  2. Else req[idx]=0: abort pulse; setpoint unchanged.
  3. Else cnt==TIMEOUT_CYC-1: timeout pulse; setpoint unchanged.
  4. Else cnt++.
- Cases 1-3 move to RELEASE on the next edge: grant=0, conf_start=0, done_room=idx, ptr=idx.
- State RELEASE:
  - Holds conf_start=0 and busy=1 for exactly GAP_CYC cycles, then returns to IDLE.
  - Requests arriving during RELEASE wait. They are evaluated in IDLE with the updated ptr.
- Simultaneous events:
  - conf_hit and req drop in the same cycle: done wins, value captured.
  - conf_hit on the timeout cycle: done wins.
- Fairness: a room served last has lowest priority next. With all req high, the service order is 0,1,2,...,N-1,0.
- Changes to req bits of non-granted rooms have no effect during RUN/RELEASE.
- conf_hit/conf_out are ignored outside RUN.
- Reset asserted mid-session: immediate return to reset values, including setpoints; conf_start drops asynchronously.
- Pulses are high exactly one cycle. At most one of done/abort/timeout is high in any cycle.

Test Plan:
- Reset then single request: req=4'b0100 -> grant=4'b0100 and conf_start=1 one cycle later. Toggle btn[2] -> conf_in mirrors it. Drive conf_hit=1 with conf_out=4'd5 -> done=1, done_room=2, setpoints[11:8]=5, then conf_start=0 for 2 cycles, busy=0 after.
- Round-robin: req=4'b1111 held, FSM returns hits with codes 1,2,3,4 -> grants in order rooms 0,1,2,3. setpoints=16'h4321. The fifth grant goes to room 0.
- Abort: room 1 granted, drop req[1] after 10 cycles without hit -> abort pulse, done_room=1, setpoints[7:4] stays 8, no done.
- Timeout: room 3 granted, req held, no conf_hit -> timeout pulse exactly 64 cycles after grant, setpoint unchanged, conf_start low 2 cycles. Room 0 is granted next if requesting.
- Priority: conf_hit=1 with conf_out=4'd9 in the same cycle req[0] drops -> done (not abort), setpoints[3:0]=9. conf_hit during RELEASE/IDLE -> no change.
- Async reset mid-RUN: rst=0 between clock edges -> grant=0, conf_start=0 immediately, all setpoints return to 8.
